// File: rtl/clock_time_core.sv
// BCD hh:mm:ss timekeeper advanced by rising edges of the 1 Hz divider output,
// with validated time load and per-field manual increment for the set-time UI.
module clock_time_core #(
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run_en,
    input  logic       set_load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic [1:0] inc_sel,
    input  logic       inc_pulse,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       day_pulse,
    output logic       load_err
);

    localparam logic [3:0] HMAX_T   = 4'(HOUR_MAX / 10);
    localparam logic [3:0] HMAX_O   = 4'(HOUR_MAX % 10);
    localparam logic [7:0] HMAX_BCD = {HMAX_T, HMAX_O};
    localparam logic [7:0] MS_MAX   = 8'h59;

    localparam logic [1:0] SEL_SS = 2'b01;
    localparam logic [1:0] SEL_MM = 2'b10;
    localparam logic [1:0] SEL_HH = 2'b11;

    // BCD +1 with wrap to 00 once the field's last value is reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v == lim)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic ms_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Digits are checked first, so a plain compare against the BCD limit is exact.
    function automatic logic hh_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= HMAX_BCD);
    endfunction

    logic       tick_q;
    logic [7:0] hh_q, hh_d;
    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;
    logic       sec_q, sec_d;
    logic       min_q, min_d;
    logic       day_q, day_d;
    logic       err_q, err_d;
    logic       tick_rise;

    assign tick_rise = tick_in & ~tick_q;

    always_comb begin
        hh_d  = hh_q;
        mm_d  = mm_q;
        ss_d  = ss_q;
        sec_d = 1'b0;
        min_d = 1'b0;
        day_d = 1'b0;
        err_d = 1'b0;

        if (set_load) begin
            hh_d  = hh_ok(set_hh) ? set_hh : 8'h00;
            mm_d  = ms_ok(set_mm) ? set_mm : 8'h00;
            ss_d  = ms_ok(set_ss) ? set_ss : 8'h00;
            err_d = ~(hh_ok(set_hh) & ms_ok(set_mm) & ms_ok(set_ss));
        end else if (inc_pulse && inc_sel != 2'b00) begin
            case (inc_sel)
                SEL_SS:  ss_d = bcd_inc(ss_q, MS_MAX);
                SEL_MM:  mm_d = bcd_inc(mm_q, MS_MAX);
                SEL_HH:  hh_d = bcd_inc(hh_q, HMAX_BCD);
                default: ;
            endcase
        end else if (tick_rise && run_en) begin
            sec_d = 1'b1;
            ss_d  = bcd_inc(ss_q, MS_MAX);
            if (ss_q == MS_MAX) begin
                min_d = 1'b1;
                mm_d  = bcd_inc(mm_q, MS_MAX);
                if (mm_q == MS_MAX) begin
                    hh_d = bcd_inc(hh_q, HMAX_BCD);
                    if (hh_q == HMAX_BCD)
                        day_d = 1'b1;
                end
            end
        end
    end

    // tick_q resets high so a level already high at reset release is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b1;
            hh_q   <= 8'h00;
            mm_q   <= 8'h00;
            ss_q   <= 8'h00;
            sec_q  <= 1'b0;
            min_q  <= 1'b0;
            day_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tick_q <= tick_in;
            hh_q   <= hh_d;
            mm_q   <= mm_d;
            ss_q   <= ss_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            day_q  <= day_d;
            err_q  <= err_d;
        end
    end

    assign hh        = hh_q;
    assign mm        = mm_q;
    assign ss        = ss_q;
    assign sec_pulse = sec_q;
    assign min_pulse = min_q;
    assign day_pulse = day_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core: tick edges, rollovers, load validation,
// manual increment, priority collisions and asynchronous reset.
module tb_clock_time_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       run_en;
    logic       set_load;
    logic [7:0] set_hh, set_mm, set_ss;
    logic [1:0] inc_sel;
    logic       inc_pulse;
    logic [7:0] hh, mm, ss;
    logic       sec_pulse, min_pulse, day_pulse, load_err;

    int n_chk = 0;
    int n_err = 0;
    int sec_cnt = 0, min_cnt = 0, day_cnt = 0;

    clock_time_core #(.HOUR_MAX(23)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .run_en(run_en),
        .set_load(set_load), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .inc_sel(inc_sel), .inc_pulse(inc_pulse),
        .hh(hh), .mm(mm), .ss(ss),
        .sec_pulse(sec_pulse), .min_pulse(min_pulse), .day_pulse(day_pulse),
        .load_err(load_err)
    );

    always #10 clk = ~clk;

    // Pulse counters sample on the rising edge, i.e. the pulse of the previous cycle.
    always @(posedge clk) begin
        if (sec_pulse) sec_cnt <= sec_cnt + 1;
        if (min_pulse) min_cnt <= min_cnt + 1;
        if (day_pulse) day_cnt <= day_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [7:0] eh, em, es);
        chk({tag, ".hh"}, 32'(hh), 32'(eh));
        chk({tag, ".mm"}, 32'(mm), 32'(em));
        chk({tag, ".ss"}, 32'(ss), 32'(es));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] h, m, s);
        set_hh = h; set_mm = m; set_ss = s; set_load = 1'b1;
        cyc(1);
        set_load = 1'b0;
    endtask

    task automatic inc(input logic [1:0] sel);
        inc_sel = sel; inc_pulse = 1'b1;
        cyc(1);
        inc_pulse = 1'b0; inc_sel = 2'b00;
    endtask

    task automatic tick_edge(input int hi);
        tick_in = 1'b1;
        cyc(hi);
        tick_in = 1'b0;
        cyc(1);
    endtask

    task automatic clr_cnt();
        sec_cnt = 0; min_cnt = 0; day_cnt = 0;
    endtask

    initial begin
        rst = 1'b0; tick_in = 1'b1; run_en = 1'b1; set_load = 1'b0;
        set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
        inc_sel = 2'b00; inc_pulse = 1'b0;

        // Reset state, then release with tick_in already high: no count.
        cyc(2);
        chk_time("rst", 8'h00, 8'h00, 8'h00);
        chk("rst.sec", 32'(sec_pulse), 0);
        chk("rst.err", 32'(load_err), 0);
        rst = 1'b1;
        clr_cnt();
        cyc(3);
        chk_time("rel_high", 8'h00, 8'h00, 8'h00);
        chk("rel_high.sec_cnt", 32'(sec_cnt), 0);
        tick_in = 1'b0;
        cyc(1);

        // Seconds rollover into minutes with long-held tick levels.
        load(8'h00, 8'h00, 8'h58);
        chk_time("ld58", 8'h00, 8'h00, 8'h58);
        clr_cnt();
        tick_edge(5);
        chk_time("t59", 8'h00, 8'h00, 8'h59);
        tick_edge(5);
        chk_time("t100", 8'h00, 8'h01, 8'h00);
        chk("t100.sec_cnt", 32'(sec_cnt), 2);
        chk("t100.min_cnt", 32'(min_cnt), 1);
        chk("t100.day_cnt", 32'(day_cnt), 0);

        // Day rollover: all three pulses together, one cycle only.
        load(8'h23, 8'h59, 8'h59);
        tick_in = 1'b1;
        cyc(1);
        chk_time("day", 8'h00, 8'h00, 8'h00);
        chk("day.sec", 32'(sec_pulse), 1);
        chk("day.min", 32'(min_pulse), 1);
        chk("day.day", 32'(day_pulse), 1);
        tick_in = 1'b0;
        cyc(1);
        chk("day.sec_off", 32'(sec_pulse), 0);
        chk("day.day_off", 32'(day_pulse), 0);

        // Mid-minute BCD carry 09 -> 10.
        load(8'h09, 8'h00, 8'h09);
        tick_edge(1);
        chk_time("bcd9", 8'h09, 8'h00, 8'h10);

        // Load validation.
        load(8'h24, 8'h61, 8'h5A);
        chk_time("bad", 8'h00, 8'h00, 8'h00);
        chk("bad.err", 32'(load_err), 1);
        cyc(1);
        chk("bad.err_off", 32'(load_err), 0);
        load(8'h12, 8'h34, 8'h56);
        chk_time("good", 8'h12, 8'h34, 8'h56);
        chk("good.err", 32'(load_err), 0);
        load(8'h19, 8'h60, 8'h07);
        chk_time("part", 8'h19, 8'h00, 8'h07);
        chk("part.err", 32'(load_err), 1);
        load(8'h23, 8'h1F, 8'h59);
        chk_time("digit", 8'h23, 8'h00, 8'h59);
        chk("digit.err", 32'(load_err), 1);

        // Manual increment: wrap within field, no carries, no pulses.
        load(8'h10, 8'h59, 8'h30);
        inc(2'b10);
        chk_time("inc_mm", 8'h10, 8'h00, 8'h30);
        chk("inc_mm.sec", 32'(sec_pulse), 0);
        chk("inc_mm.min", 32'(min_pulse), 0);
        load(8'h23, 8'h15, 8'h20);
        inc(2'b11);
        chk_time("inc_hh", 8'h00, 8'h15, 8'h20);
        chk("inc_hh.day", 32'(day_pulse), 0);
        load(8'h01, 8'h02, 8'h59);
        inc(2'b01);
        chk_time("inc_ss", 8'h01, 8'h02, 8'h00);
        chk("inc_ss.min", 32'(min_pulse), 0);

        // inc_sel=00 is a no-op and lets a coincident tick through.
        load(8'h01, 8'h02, 8'h03);
        tick_in = 1'b1; inc_pulse = 1'b1; inc_sel = 2'b00;
        cyc(1);
        inc_pulse = 1'b0;
        chk_time("inc00", 8'h01, 8'h02, 8'h04);
        chk("inc00.sec", 32'(sec_pulse), 1);
        tick_in = 1'b0;
        cyc(1);

        // Load beats a coincident tick; the tick is dropped, not deferred.
        set_hh = 8'h05; set_mm = 8'h05; set_ss = 8'h05; set_load = 1'b1;
        tick_in = 1'b1;
        cyc(1);
        set_load = 1'b0;
        chk_time("ld_tick", 8'h05, 8'h05, 8'h05);
        chk("ld_tick.sec", 32'(sec_pulse), 0);
        cyc(3);
        chk_time("ld_tick_hold", 8'h05, 8'h05, 8'h05);
        tick_in = 1'b0;
        cyc(1);

        // Increment beats a coincident tick.
        tick_in = 1'b1;
        inc(2'b01);
        chk_time("inc_tick", 8'h05, 8'h05, 8'h06);
        chk("inc_tick.sec", 32'(sec_pulse), 0);
        tick_in = 1'b0;
        cyc(1);

        // Frozen time: edges lost, increment still works.
        run_en = 1'b0;
        clr_cnt();
        tick_edge(2); tick_edge(2); tick_edge(2);
        chk_time("frozen", 8'h05, 8'h05, 8'h06);
        chk("frozen.sec_cnt", 32'(sec_cnt), 0);
        inc(2'b11);
        chk_time("frozen_inc", 8'h06, 8'h05, 8'h06);
        run_en = 1'b1;

        // Asynchronous reset between clock edges.
        load(8'h12, 8'h34, 8'h56);
        #5;
        rst = 1'b0;
        #1;
        chk_time("async_rst", 8'h00, 8'h00, 8'h00);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk_time("post_rst", 8'h00, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/clock_time_core.md
Name: clock_time_core

Overview:
- Timekeeping stage directly downstream of the 1 Hz divider.
- Consumes the divider's square-wave output as `tick_in` and detects its rising edge in the `clk` domain.
- Each detected edge advances a BCD hh:mm:ss counter. Also supports direct time load and per-field manual increment for the set-time UI.
- Outputs feed the 7-segment display mux and the alarm comparator.

Parameters:
- HOUR_MAX, 23, last valid hour value (binary); the hour wraps HOUR_MAX -> 0.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous active-low reset
- tick_in  input  1  divided clock from divider; level signal, counted on rising edge only
- run_en  input  1  1 = tick edges advance time; 0 = time frozen
- set_load  input  1  one-cycle strobe; load set_hh/set_mm/set_ss
- set_hh  input  8  BCD hours {tens, ones}
- set_mm  input  8  BCD minutes
- set_ss  input  8  BCD seconds
- inc_sel  input  2  field select: 00 none, 01 ss, 10 mm, 11 hh
- inc_pulse  input  1  one-cycle strobe; increment selected field
- hh  output  8  BCD hours
- mm  output  8  BCD minutes
- ss  output  8  BCD seconds
- sec_pulse  output  1  one-cycle pulse on each tick advance
- min_pulse  output  1  one-cycle pulse when ss wraps 59->00 on a tick
- day_pulse  output  1  one-cycle pulse on HOUR_MAX:59:59 -> 00:00:00
- load_err  output  1  one-cycle pulse when a set_load field was invalid

Behaviour:
- Clock and reset: single clock `clk`, all flops on its rising edge. Reset `rst` is asynchronous and active-low.
- Reset values:
  - hh = mm = ss = 8'h00.
  - All pulse outputs 0.
  - Edge-detect register tick_d = 1, so a high tick_in at reset release is not counted.
- Edge detect:
  - tick_rise = tick_in & ~tick_d; tick_d <= tick_in every cycle.
  - tick_in held high N cycles yields exactly one tick_rise.
- Latency: time registers and pulses update at the same clk edge that samples tick_rise = 1. New values are visible one cycle after tick_in is first sampled high.
- Per-cycle priority (exactly one action per cycle):
  1. set_load
  2. inc_pulse with inc_sel != 00
  3. tick_rise & run_en
  4. hold
- A tick_rise coinciding with a set_load or inc action is discarded, not deferred. sec_pulse stays 0 in that cycle.
- Tick advance:
  - ss += 1.
  - If ss was 59: ss = 00, min_pulse = 1, mm += 1.
  - If mm was 59: mm = 00, hh += 1.
  - If hh was HOUR_MAX: hh = 00, day_pulse = 1.
  - sec_pulse = 1 on every advance.
- BCD arithmetic: ones digit 9 -> 0 with carry into tens. Values never leave BCD. Comparisons against 59 and HOUR_MAX are done on the BCD encoding (HOUR_MAX converted to BCD).
- Manual increment:
  - The selected field += 1 and wraps within the field: ss/mm 59 -> 00, hh HOUR_MAX -> 00.
  - No carry into other fields. No sec/min/day pulses.
  - inc_sel = 00 with inc_pulse is a no-op, and a coincident tick is still processed.
- set_load: each field is validated independently.
  - Fails if any digit > 9, mm/ss tens > 5, or hh > HOUR_MAX.
  - Valid fields load as given. Invalid fields load 8'h00.
  - load_err = 1 for that cycle if any field was invalid.
- Pulses are registered, high exactly one cycle, and coincident with the updated time values.
- run_en = 0: ticks are ignored (lost). set_load and inc still operate.
- Reset asserted mid-operation: immediate return to reset values regardless of clk. A pending edge is lost.

Test Plan:
- Reset release with tick_in = 1, run_en = 1, hold 3 cycles -> hh:mm:ss stays 00:00:00, sec_pulse stays 0.
- Load 00:00:58, then two tick_in rising edges each held high 5 cycles -> 00:00:59 then 00:01:00. Exactly 2 sec_pulse, 1 min_pulse, day_pulse 0.
- Load 23:59:59, then one tick edge -> 00:00:00 with sec_pulse, min_pulse and day_pulse all high in the same cycle.
- set_load with set_hh = 8'h24, set_mm = 8'h61, set_ss = 8'h5A -> 00:00:00, load_err = 1 for one cycle. Then load 12:34:56 -> 12:34:56, load_err = 0.
- Load 10:59:30, inc_sel = 10, inc_pulse -> 10:00:30, no pulses. With inc_sel = 11 and hh = 23 -> hh = 00, mm/ss unchanged.
- Simultaneity: set_load of 05:05:05 in the same cycle as tick_rise -> 05:05:05, sec_pulse = 0. With run_en = 0, 3 edges -> time unchanged. Reset asserted between clk edges -> outputs 00 immediately.
